dtc_seq_eval: RTL

DTC_SEQ_EVAL -- requirements
Module: dtc_seq_eval

---
 rtl/dtc_pkg.sv | 42 ++++
 rtl/dtc_node_table.sv | 40 ++++
 rtl/dtc_seq_eval.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/dtc_pkg.sv
// Shared definitions for the sequential decision-tree evaluator.
// Holds the node record layout, width helpers and the controller state type.
// Node packing (MSB..LSB): {leaf, feat_idx, thresh, left, right, cls}.
package dtc_pkg;

  localparam int unsigned DEF_N_FEAT    = 10;
  localparam int unsigned DEF_FEAT_W    = 1;
  localparam int unsigned DEF_CLASS_W   = 3;
  localparam int unsigned DEF_MAX_NODES = 64;

  // $clog2 that never returns 0, so single-entry fields stay 1 bit wide.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  function automatic int unsigned node_w(input int unsigned n_feat,
                                         input int unsigned feat_w,
                                         input int unsigned class_w,
                                         input int unsigned max_nodes);
    return 1 + clog2_min1(n_feat) + feat_w + 2 * clog2_min1(max_nodes) + class_w;
  endfunction

  localparam int unsigned DEF_FIDX_W = clog2_min1(DEF_N_FEAT);
  localparam int unsigned DEF_ADDR_W = clog2_min1(DEF_MAX_NODES);
  localparam int unsigned NODE_W     = node_w(DEF_N_FEAT, DEF_FEAT_W, DEF_CLASS_W, DEF_MAX_NODES);

  typedef struct packed {
    logic                   leaf;
    logic [DEF_FIDX_W-1:0]  feat_idx;
    logic [DEF_FEAT_W-1:0]  thresh;
    logic [DEF_ADDR_W-1:0]  left;
    logic [DEF_ADDR_W-1:0]  right;
    logic [DEF_CLASS_W-1:0] cls;
  } node_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALK = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dtc_node_table.sv
// Node table for the decision-tree evaluator.
// One synchronous write port, one asynchronous read port.
// Reset turns every entry into a leaf with class 0 (leaf flag is the MSB).
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   we/waddr/wdata  - write strobe, entry index, packed node
//   raddr/rdata     - combinational read of one entry
module dtc_node_table
  import dtc_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NW     = NODE_W,
  parameter int unsigned DEPTH  = DEF_MAX_NODES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [NW-1:0]     wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [NW-1:0]     rdata
);

  localparam logic [NW-1:0] RST_NODE = {1'b1, {(NW-1){1'b0}}};

  logic [NW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= RST_NODE;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/dtc_seq_eval.sv
// Sequential decision-tree evaluator: walks a configurable node table one
// node per cycle for each accepted feature vector and returns a class label.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   cfg_we/cfg_addr/cfg_data       - node-table write (accepted only when cfg_ready)
//   cfg_ready                      - table writable (idle)
//   in_valid/in_ready/in_data      - sample handshake and feature vector
//   out_valid/out_ready            - result handshake
//   out_class/out_err              - predicted class, depth/feature-index error
//   perf_samples/perf_cycles       - only with DTC_PERF_EN: completed results and
//                                    cycles spent walking
// Optional feature macro: DTC_PERF_EN
module dtc_seq_eval
  import dtc_pkg::*;
#(
  parameter int unsigned N_FEAT    = 10,
  parameter int unsigned FEAT_W    = 1,
  parameter int unsigned CLASS_W   = 3,
  parameter int unsigned MAX_NODES = 64,
  parameter int unsigned MAX_DEPTH = 8,
  localparam int unsigned ADDR_W   = clog2_min1(MAX_NODES),
  localparam int unsigned NW       = node_w(N_FEAT, FEAT_W, CLASS_W, MAX_NODES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [NW-1:0]            cfg_data,
  output logic                     cfg_ready,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err
`ifdef DTC_PERF_EN
  ,
  output logic [31:0]              perf_samples,
  output logic [31:0]              perf_cycles
`endif
);

  localparam int unsigned FIDX_W  = clog2_min1(N_FEAT);
  localparam int unsigned DEPTH_W = clog2_min1(MAX_DEPTH);

  // Field offsets inside a packed node, LSB first.
  localparam int unsigned O_CLS   = 0;
  localparam int unsigned O_RIGHT = O_CLS + CLASS_W;
  localparam int unsigned O_LEFT  = O_RIGHT + ADDR_W;
  localparam int unsigned O_THR   = O_LEFT + ADDR_W;
  localparam int unsigned O_FIDX  = O_THR + FEAT_W;
  localparam int unsigned O_LEAF  = O_FIDX + FIDX_W;

  state_t                    r_state;
  logic                      r_in_ready;
  logic                      r_out_valid;
  logic [CLASS_W-1:0]        r_class;
  logic                      r_err;
  logic [ADDR_W-1:0]         r_ptr;
  logic [DEPTH_W-1:0]        r_depth;
  logic [N_FEAT*FEAT_W-1:0]  r_sample;

  logic [NW-1:0]             w_node;
  logic                      w_leaf;
  logic [FIDX_W-1:0]         w_fidx;
  logic [FEAT_W-1:0]         w_thr;
  logic [ADDR_W-1:0]         w_left;
  logic [ADDR_W-1:0]         w_right;
  logic [CLASS_W-1:0]        w_cls;
  logic [FEAT_W-1:0]         w_fval;
  logic                      w_fidx_ok;
  logic                      w_tab_we;

  // Table is writable only while idle; the write lands on the same edge that
  // accepts a sample, so the first node visit already sees it.
  assign w_tab_we = cfg_we & r_in_ready;

  dtc_node_table #(
    .ADDR_W (ADDR_W),
    .NW     (NW),
    .DEPTH  (MAX_NODES)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (w_tab_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (r_ptr),
    .rdata (w_node)
  );

  assign w_leaf  = w_node[O_LEAF];
  assign w_fidx  = w_node[O_FIDX +: FIDX_W];
  assign w_thr   = w_node[O_THR +: FEAT_W];
  assign w_left  = w_node[O_LEFT +: ADDR_W];
  assign w_right = w_node[O_RIGHT +: ADDR_W];
  assign w_cls   = w_node[O_CLS +: CLASS_W];

  // Feature mux with explicit range check so an out-of-range index never
  // produces an out-of-bounds part-select.
  always_comb begin
    w_fval    = '0;
    w_fidx_ok = 1'b0;
    for (int unsigned i = 0; i < N_FEAT; i++) begin
      if (w_fidx == FIDX_W'(i)) begin
        w_fval    = r_sample[i*FEAT_W +: FEAT_W];
        w_fidx_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_class     <= '0;
      r_err       <= 1'b0;
      r_ptr       <= '0;
      r_depth     <= '0;
      r_sample    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sample   <= in_data;
            r_ptr      <= '0;
            r_depth    <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_WALK;
          end
        end
        S_WALK: begin
          if (w_leaf) begin
            r_class     <= w_cls;
            r_err       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (!w_fidx_ok || (r_depth == DEPTH_W'(MAX_DEPTH - 1))) begin
            // Last permitted visit was not a leaf, or the feature index is bad.
            r_class     <= '0;
            r_err       <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_ptr   <= (w_fval > w_thr) ? w_right : w_left;
            r_depth <= r_depth + DEPTH_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign cfg_ready = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_class = r_class;
  assign out_err   = r_err;

`ifdef DTC_PERF_EN
  logic [31:0] r_perf_samples;
  logic [31:0] r_perf_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_samples <= '0;
      r_perf_cycles  <= '0;
    end else begin
      if ((r_state == S_DONE) && out_ready) begin
        r_perf_samples <= r_perf_samples + 32'd1;
      end
      if (r_state == S_WALK) begin
        r_perf_cycles <= r_perf_cycles + 32'd1;
      end
    end
  end

  assign perf_samples = r_perf_samples;
  assign perf_cycles  = r_perf_cycles;
`endif

endmodule
